prbg_pattern_engine: RTL and testbench
======================================

// Module: prbg_pattern_engine
// PURPOSE
//  Parametrised successor to the 4-bit shift-add pattern generator. Seeds a WIDTH-bit
//  pattern register, then steps it each accepted beat through one of three update rules
//  (shift-add, Galois LFSR, stride counter). Words go out on a valid/ready stream to the
//  pattern detector. Bursts are of programmable length, or free-running.
// PARAMETERS
//  WIDTH   8      pattern width in bits (>=4)
//  SHIFT_W 3      width of shift amount r
//  ADD_W   3      width of addend b
//  CNT_W   16     width of burst length / beat counter
//  TAPS    8'hB8  Galois LFSR feedback mask, WIDTH bits (default maximal, period 255)
// PORTS
//  clk        in   1       rising-edge clock
//  res        in   1       synchronous active-high reset
//  start      in   1       begin burst; sampled only in IDLE
//  stop       in   1       abort burst; sampled only in RUN
//  seed       in   WIDTH   initial pattern, captured on accepted start
//  mode       in   2       0 shift-add, 1 LFSR, 2 counter, 3 reserved (acts as 0)
//  r          in   SHIFT_W shift amount (mode 0)
//  b          in   ADD_W   addend (mode 0), stride-1 (mode 2)
//  burst_len  in   CNT_W   beats per burst; 0 = free-run until stop
//  pat_ready  in   1       downstream accepts pat_out
//  pat_out    out  WIDTH   current pattern word
//  pat_valid  out  1       pat_out is valid
//  busy       out  1       high in RUN
//  done       out  1       1-cycle pulse, burst completed normally
//  seed_fix   out  1       1-cycle pulse, zero LFSR seed replaced by 1
// BEHAVIOUR
//  Reset (res=1 at clk edge, overrides everything):
//   - state=IDLE; pat_out=0; pat_valid, busy, done, seed_fix=0; beat counter=0.
//  FSM states: IDLE, RUN.
//  IDLE, start=1:
//   - capture mode, r, b and burst_len into config registers; inputs ignored until next start
//   - pat_out<=seed; pat_valid<=1; count<=0; state<=RUN
//   - if captured mode==1 and seed==0: load 1, pulse seed_fix
//  RUN:
//   - transfer = pat_valid & pat_ready
//   - no transfer: pat_out and pat_valid hold stable (strict valid/ready rule)
//   - transfer, not last beat: count++, pat_out<=next(pat_out)
//   - last beat is burst_len!=0 && count==burst_len-1:
//     pat_valid<=0, done<=1 for one cycle, state<=IDLE
//   - stop=1: state<=IDLE, pat_valid<=0, no done; this beat's transfer counts,
//     pat_out not advanced
//   - start ignored while in RUN
//  Next rules, all results taken mod 2^WIDTH:
//   - mode 0/3: cur + (cur<<r) + zero-extended b
//   - mode 1:   cur[0] ? (cur>>1)^TAPS : cur>>1
//   - mode 2:   cur + b + 1
//  Single-cycle update: no pipeline bubble; back-to-back beats possible every cycle.
//  Free-run (burst_len=0): count wraps at 2^CNT_W silently; done is never asserted.
//  busy==(state==RUN); pat_valid==busy.
//  done and seed_fix are never high for more than one cycle.
//  Next start is accepted the cycle done is high (state already IDLE).
// TESTING
//  1 mode0 seed=3 r=1 b=2 len=5 ready=1 -> pat_out 3,11,35,107,67; done 1 cycle later
//  2 mode1 seed=0x01 len=3 -> 0x01,0xB8,0x5C; free-run from 0x01 revisits 0x01 after 255 beats
//  3 mode1 seed=0 -> seed_fix pulse; first word 0x01
//  4 mode2 seed=0xFE b=1 len=3 -> 0xFE,0x00,0x02 (wrap)
//  5 ready low 3 cycles mid-burst -> pat_out/pat_valid stable; beats and count unchanged
//  6 res=1 mid-burst, then stop in free-run -> all outputs 0 / IDLE next cycle; no done;
//    following start works

Source files
------------

// File: rtl/prbg_pattern_engine_if.sv
// Pattern word stream between the engine and the pattern detector.
// The master drives word and valid; the slave drives ready.
interface prbg_pattern_engine_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pat_out;
  logic             pat_valid;
  logic             pat_ready;

  modport master (
    output pat_out,
    output pat_valid,
    input  pat_ready
  );

  modport slave (
    input  pat_out,
    input  pat_valid,
    output pat_ready
  );
endinterface

// File: rtl/prbg_pattern_engine.sv
// Seeded pattern generator with shift-add, Galois LFSR and stride rules.
// Bursts are programmable in length or free-running until stop.
module prbg_pattern_engine #(
  parameter int               WIDTH   = 8,
  parameter int               SHIFT_W = 3,
  parameter int               ADD_W   = 3,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] TAPS    = 8'hB8
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  input  logic                   stop,
  input  logic [WIDTH-1:0]       seed,
  input  logic [1:0]             mode,
  input  logic [SHIFT_W-1:0]     r,
  input  logic [ADD_W-1:0]       b,
  input  logic [CNT_W-1:0]       burst_len,
  prbg_pattern_engine_if.master  pat,
  output logic                   busy,
  output logic                   done,
  output logic                   seed_fix
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_pat;
  logic               r_valid;
  logic               r_done;
  logic               r_fix;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_mode;
  logic [SHIFT_W-1:0] r_shamt;
  logic [ADD_W-1:0]   r_add;
  logic [CNT_W-1:0]   r_len;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_pat_nxt;
  logic               w_valid_nxt;
  logic               w_done_nxt;
  logic               w_fix_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_cfg_ld;
  logic [WIDTH-1:0]   w_step;
  logic               w_xfer;
  logic               w_last;

  assign w_xfer = r_valid & pat.pat_ready;
  assign w_last = (r_len != '0) &&
                  (r_cnt == r_len - CNT_W'(1));

  always_comb begin
    w_step = '0;
    unique case (r_mode)
      2'd1: w_step = r_pat[0] ? ((r_pat >> 1) ^ TAPS)
                              : (r_pat >> 1);
      2'd2: w_step = r_pat + WIDTH'(r_add) + WIDTH'(1);
      default:
        w_step = r_pat + (r_pat << r_shamt)
               + WIDTH'(r_add);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_fix_nxt   = 1'b0;
    w_cfg_ld    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cfg_ld    = 1'b1;
          w_state_nxt = S_RUN;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          // An all-zero LFSR state would lock up
          w_fix_nxt   = (mode == 2'd1) && (seed == '0);
          w_pat_nxt   = w_fix_nxt ? WIDTH'(1) : seed;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          if (w_xfer) w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_xfer) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_pat_nxt = w_step;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_fix   <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_shamt <= '0;
      r_add   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_fix   <= w_fix_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cfg_ld) begin
        r_mode  <= mode;
        r_shamt <= r;
        r_add   <= b;
        r_len   <= burst_len;
      end
    end
  end

  assign pat.pat_out   = r_pat;
  assign pat.pat_valid = r_valid;
  assign busy          = (r_state == S_RUN);
  assign done          = r_done;
  assign seed_fix      = r_fix;

endmodule

// File: tb/tb_prbg_pattern_engine.sv
// Bench for prbg_pattern_engine: fixed vectors, corner sequences
// and randomized bursts checked against an arithmetic reference.
module tb_prbg_pattern_engine;

  logic        clk;
  logic        res;
  logic        start;
  logic        stop;
  logic [7:0]  seed;
  logic [1:0]  mode;
  logic [2:0]  r;
  logic [2:0]  b;
  logic [15:0] burst_len;
  logic        busy;
  logic        done;
  logic        seed_fix;

  int n_tests;
  int n_fail;

  prbg_pattern_engine_if #(.WIDTH(8)) pif ();

  prbg_pattern_engine dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .stop      (stop),
    .seed      (seed),
    .mode      (mode),
    .r         (r),
    .b         (b),
    .burst_len (burst_len),
    .pat       (pif.master),
    .busy      (busy),
    .done      (done),
    .seed_fix  (seed_fix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      m;
    logic [7:0]      sd;
    logic [2:0]      rr;
    logic [2:0]      bb;
    logic [15:0]     len;
    int              n;
    logic [4:0][7:0] w;
    bit              fix;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference next-word rule in plain integer arithmetic
  function automatic int model_next(int cur, int m, int rr, int bb);
    case (m)
      1: model_next = (cur % 2 == 1) ? ((cur / 2) ^ 'hB8) : (cur / 2);
      2: model_next = (cur + bb + 1) % 256;
      default: model_next = (cur + cur * (1 << rr) + bb) % 256;
    endcase
  endfunction

  task automatic do_burst(input logic [1:0] m, input logic [7:0] sd,
                          input logic [2:0] rr, input logic [2:0] bb,
                          input logic [15:0] len, input int rdy_pct,
                          input int stop_at);
    int cur;
    int beats;
    bit fix_exp;
    bit rdy;
    bit fin;
    start = 1'b1; stop = 1'b0;
    mode = m; seed = sd; r = rr; b = bb; burst_len = len;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); seed = 8'($urandom);
    r = 3'($urandom); b = 3'($urandom);
    burst_len = 16'($urandom_range(1, 3));
    fix_exp = (m == 2'd1) && (sd == 8'd0);
    cur = fix_exp ? 1 : int'(sd);
    beats = 0;
    fin = 1'b0;
    chk("seed_fix", int'(seed_fix), int'(fix_exp));
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      chk("valid", int'(pif.pat_valid), 1);
      chk("busy", int'(busy), 1);
      chk("pat_out", int'(pif.pat_out), cur);
      chk("done_low", int'(done), 0);
      if (cyc > 0) chk("seed_fix_pulse", int'(seed_fix), 0);
      rdy = ($urandom_range(99) < rdy_pct);
      pif.pat_ready = rdy;
      start = 1'($urandom);
      if (stop_at >= 0 && beats == stop_at) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0; pif.pat_ready = 1'b0;
        chk("stop_valid", int'(pif.pat_valid), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_no_done", int'(done), 0);
        fin = 1'b1;
      end else begin
        if (rdy) begin
          beats++;
          if (len != 0 && beats == int'(len)) begin
            @(negedge clk);
            start = 1'b0; pif.pat_ready = 1'b0;
            chk("end_valid", int'(pif.pat_valid), 0);
            chk("end_busy", int'(busy), 0);
            chk("end_done", int'(done), 1);
            fin = 1'b1;
          end else begin
            cur = model_next(cur, int'(m), int'(rr), int'(bb));
          end
        end
        if (!fin) @(negedge clk);
      end
    end
    start = 1'b0;
    if (!fin) chk("burst_timeout", 0, 1);
  endtask

  initial begin
    int  k;
    bit  early;
    n_tests = 0;
    n_fail  = 0;
    res = 1'b1; start = 1'b0; stop = 1'b0;
    seed = '0; mode = '0; r = '0; b = '0; burst_len = '0;
    pif.pat_ready = 1'b0;

    vecs[0] = '{2'd0, 8'd3,   3'd1, 3'd2, 16'd5, 5,
                {8'd67, 8'd107, 8'd35, 8'd11, 8'd3}, 1'b0};
    vecs[1] = '{2'd1, 8'h01,  3'd0, 3'd0, 16'd3, 3,
                {8'h00, 8'h00, 8'h5C, 8'hB8, 8'h01}, 1'b0};
    vecs[2] = '{2'd1, 8'h00,  3'd0, 3'd0, 16'd2, 2,
                {8'h00, 8'h00, 8'h00, 8'hB8, 8'h01}, 1'b1};
    vecs[3] = '{2'd2, 8'hFE,  3'd0, 3'd1, 16'd3, 3,
                {8'h00, 8'h00, 8'h02, 8'h00, 8'hFE}, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    chk("rst_pat", int'(pif.pat_out), 0);
    chk("rst_valid", int'(pif.pat_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fix", int'(seed_fix), 0);

    foreach (vecs[i]) begin
      start = 1'b1; mode = vecs[i].m; seed = vecs[i].sd;
      r = vecs[i].rr; b = vecs[i].bb; burst_len = vecs[i].len;
      pif.pat_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < vecs[i].n; j++) begin
        chk($sformatf("vec%0d_w%0d", i, j), int'(pif.pat_out),
            int'(vecs[i].w[j]));
        chk($sformatf("vec%0d_fix%0d", i, j), int'(seed_fix),
            (j == 0) ? int'(vecs[i].fix) : 0);
        @(negedge clk);
      end
      chk($sformatf("vec%0d_done", i), int'(done), 1);
      chk($sformatf("vec%0d_idle", i), int'(pif.pat_valid), 0);
      pif.pat_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
    end

    // LFSR free-run must return to the seed after exactly 255 beats
    start = 1'b1; mode = 2'd1; seed = 8'h01; burst_len = 16'd0;
    pif.pat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    early = 1'b0;
    for (int j = 1; j < 255; j++) begin
      @(negedge clk);
      if (pif.pat_out == 8'h01) early = 1'b1;
    end
    @(negedge clk);
    chk("lfsr_no_early_repeat", int'(early), 0);
    chk("lfsr_period", int'(pif.pat_out), 1);
    chk("lfsr_no_done", int'(done), 0);
    stop = 1'b1; pif.pat_ready = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    chk("lfsr_stop_busy", int'(busy), 0);

    // Stall: word and valid hold while ready is low
    start = 1'b1; mode = 2'd2; seed = 8'd10; b = 3'd2; burst_len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    pif.pat_ready = 1'b1;
    @(negedge clk);
    pif.pat_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_pat", int'(pif.pat_out), 13);
      chk("stall_valid", int'(pif.pat_valid), 1);
    end
    pif.pat_ready = 1'b1;
    @(negedge clk);
    chk("stall_resume", int'(pif.pat_out), 16);
    @(negedge clk);
    chk("stall_last", int'(pif.pat_out), 19);
    @(negedge clk);
    chk("stall_done", int'(done), 1);
    pif.pat_ready = 1'b0;

    // Reset mid-burst clears everything, no done
    start = 1'b1; mode = 2'd0; seed = 8'd5; r = 3'd2; b = 3'd1;
    burst_len = 16'd20;
    @(negedge clk);
    start = 1'b0; pif.pat_ready = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0; pif.pat_ready = 1'b0;
    chk("mid_rst_pat", int'(pif.pat_out), 0);
    chk("mid_rst_valid", int'(pif.pat_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);

    do_burst(2'd0, 8'd7, 3'd1, 3'd3, 16'd0, 100, 6);
    do_burst(2'd1, 8'd0, 3'd0, 3'd0, 16'd4, 100, -1);
    do_burst(2'd3, 8'd9, 3'd2, 3'd5, 16'd3, 70, -1);
    do_burst(2'd2, 8'd250, 3'd0, 3'd7, 16'd6, 50, 2);

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 12);
      do_burst(2'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
               16'(k), 60,
               (k == 0 || $urandom_range(3) == 0) ?
                 int'($urandom_range(0, 15)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
